cp0: RTL and testbench
======================

# cp0

Coprocessor-0 unit for the single-cycle MIPS core. It sits directly downstream of the main control unit and consumes that unit's `syscall`, `brk`, `cp0_rd`, `cp0_wr` and `eret` decodes. It also takes the ALU overflow, the reserved-instruction flag and the external interrupt lines. It produces the `exception` signal the control unit uses to cancel writes and redirect to the handler, the EPC target for `eret`, and `mfc0` read data; it holds Status, Cause, EPC and the optional Count/Compare timer.

## Interface
- `PRID`, 32'h0000_0100, value returned for reads of register 15 (PRId)
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `inst_pc`  in  32  PC of the instruction executing this cycle
- `syscall`  in  1  current instruction is `syscall`
- `brk`  in  1  current instruction is `break`
- `ri`  in  1  current instruction is reserved/unknown
- `ov`  in  1  ALU signed overflow for the current instruction
- `int_req`  in  6  external interrupt request lines, level-sensitive
- `eret`  in  1  current instruction is `eret`
- `cp0_rd`  in  1  `mfc0`; `rdata` is consumed this cycle
- `cp0_wr`  in  1  `mtc0`; write at end of cycle
- `reg_addr`  in  5  CP0 register number (instruction rd field)
- `wdata`  in  32  `mtc0` write data (GPR rt)
- `rdata`  out  32  combinational read of `reg_addr`
- `exception`  out  1  combinational; take exception this cycle
- `epc`  out  32  current EPC register, used as `eret` target

## Operation
- Status (12): bit0 IE, bit1 EXL, bits 15:10 IM; other bits read 0. `mtc0` writes only IE, EXL and IM.
- Cause (13): bits 15:10 IP and bits 6:2 ExcCode, both read-only; other bits read 0. `mtc0` to Cause is ignored.
- EPC (14): full 32-bit read/write.
- `rdata` decode: 12, 13 and 14 return the registers above; 15 returns `PRID`; 9 and 11 return Count/Compare when the timer is compiled in; every other address returns 0.
- IP update: every edge, IP[14:10] <= `int_req`[4:0] and IP[15] <= `int_req`[5] | `timer_pend`.
- Interrupt condition: `int_pending` = IE & ~EXL & |(IP & IM) & ~`eret`.
- Exception priority, highest first:
  - `ri` -> ExcCode 10
  - `syscall` -> 8
  - `brk` -> 9
  - `ov` -> 12
  - `int_pending` -> 0
- `exception` = any of the above conditions, forced to 0 while `rst_n` is low.
- On an edge with `exception` = 1:
  - EPC <= `inst_pc`, including interrupts; the interrupted instruction is re-executed after `eret`.
  - ExcCode <= code of the highest-priority source.
  - EXL <= 1.
  - Any `mtc0` or `eret` in the same cycle is suppressed.
- On an edge with `eret` = 1 and no exception: EXL <= 0. The `epc` output already presents the target during that cycle.
- On an edge with `cp0_wr` = 1 and no exception: write `wdata` to `reg_addr`.
- Reset values: Status, Cause, EPC, Count, Compare, `timer_pend` all 0. Consequently `rdata` = 0 for all addresses except 15, which returns `PRID`; `epc` = 0.

## Timing
- `exception`, `rdata` and `epc` are combinational from the current inputs and registers; there is no added latency.
- The core must evaluate `exception` within the same cycle so that the control unit can cancel writes.
- Register effects become visible the cycle after the edge. An `mfc0` directly after an `mtc0` reads the new value.
- An interrupt is recognised one cycle after `int_req` rises, because IP is registered.
- While EXL = 1, interrupts are blocked. Synchronous exceptions are still taken: EPC and ExcCode are overwritten and EXL stays 1.
- Reset asserted mid-instruction clears all state immediately. The first edge after release performs normal updates.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count (9) increments by 1 each edge, wrapping at 2^32.
  - An `mtc0` to Count loads `wdata` instead of incrementing.
  - Compare (11) is read/write; writing Compare clears `timer_pend`.
  - When Count == Compare and Compare != 0, `timer_pend` <= 1 (sticky).
- `CP0_TIMER_EN` undefined: no Count/Compare state, addresses 9 and 11 read 0, and `timer_pend` is constant 0.

## Test plan
- Reset: hold `rst_n` low -> `exception` = 0, `epc` = 0, `rdata` at 12 = 0, `rdata` at 15 = `PRID`. Release -> all registers remain 0.
- Syscall: `syscall` = 1 with `inst_pc` = 0x0040_0010 -> `exception` = 1 that cycle. Next cycle EPC = 0x0040_0010, Cause[6:2] = 8, Status[1] = 1. Then `eret` -> Status[1] = 0 and `epc` = 0x0040_0010.
- Priority with write suppression: `ri` = 1, `ov` = 1 and `cp0_wr` to EPC with 0xDEAD_BEEF in the same cycle -> ExcCode = 10, EPC = `inst_pc`, no 0xDEAD_BEEF written.
- Interrupt masking: write Status = 0x0000_0401 (IE = 1, IM[10] = 1), drive `int_req` = 6'b000001 -> `exception` asserts on the second cycle with ExcCode 0. With EXL = 1, or with an `eret` in the same cycle, `exception` = 0.
- Timer (`CP0_TIMER_EN`): write Compare = 5, Count = 0, Status = 0x0000_8001 -> Count reaches 5, then IP[15] sets and `exception` fires with ExcCode 0. Writing Compare clears IP[15] on the following edge.
- Read decode: `mfc0` at addresses 0, 9, 11 and 31 without the macro -> `rdata` = 0. `mtc0` 0xFFFF_FFFF to Status -> reads back 0x0000_FC03.

Source files
------------

// File: rtl/cp0_if.sv
// Bus between the main control unit and the coprocessor-0 unit.
// The core side uses the master modport; cp0 uses the slave modport.
interface cp0_if;
  logic [31:0] inst_pc;
  logic        syscall;
  logic        brk;
  logic        ri;
  logic        ov;
  logic [5:0]  int_req;
  logic        eret;
  logic        cp0_rd;
  logic        cp0_wr;
  logic [4:0]  reg_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exception;
  logic [31:0] epc;

  // There is no valid/ready handshake: every input is qualified by the
  // single-cycle instruction that is executing, and every output is
  // combinational within that same cycle.
  modport master (
    output inst_pc, syscall, brk, ri, ov, int_req, eret,
    output cp0_rd, cp0_wr, reg_addr, wdata,
    input  rdata, exception, epc
  );

  modport slave (
    input  inst_pc, syscall, brk, ri, ov, int_req, eret,
    input  cp0_rd, cp0_wr, reg_addr, wdata,
    output rdata, exception, epc
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: Status, Cause, EPC, exception priority and mfc0/mtc0.
// Define CP0_TIMER_EN to build in the Count/Compare timer.
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_0100
) (
  input logic  clk,
  input logic  rst_n,
  cp0_if.slave bus
);

  logic        ie_q, exl_q;
  logic [5:0]  im_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic        timer_pend;

  logic        int_pending;
  logic        exc_raw;
  logic [4:0]  exc_code_d;
  logic        wr_en;

  assign int_pending = ie_q & ~exl_q & (|(ip_q & im_q)) & ~bus.eret;
  assign exc_raw     = bus.ri | bus.syscall | bus.brk | bus.ov | int_pending;
  assign bus.exception = exc_raw & rst_n;
  assign bus.epc       = epc_q;
  assign wr_en         = bus.cp0_wr & ~bus.exception;

  always_comb begin
    exc_code_d = 5'd0;
    if (bus.ri)           exc_code_d = 5'd10;
    else if (bus.syscall) exc_code_d = 5'd8;
    else if (bus.brk)     exc_code_d = 5'd9;
    else if (bus.ov)      exc_code_d = 5'd12;
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q;
  logic        timer_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_pend_q <= 1'b0;
    end else begin
      if (wr_en && bus.reg_addr == 5'd9) count_q <= bus.wdata;
      else                               count_q <= count_q + 32'd1;
      if (wr_en && bus.reg_addr == 5'd11) begin
        compare_q    <= bus.wdata;
        timer_pend_q <= 1'b0;
      end else if (count_q == compare_q && compare_q != 32'd0) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  assign timer_pend = timer_pend_q;
`else
  assign timer_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= 6'd0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      ip_q <= {bus.int_req[5] | timer_pend, bus.int_req[4:0]};
      if (bus.exception) begin
        // Interrupts also save the current PC so the instruction re-executes.
        epc_q      <= bus.inst_pc;
        exc_code_q <= exc_code_d;
        exl_q      <= 1'b1;
      end else begin
        if (bus.eret) exl_q <= 1'b0;
        if (bus.cp0_wr) begin
          case (bus.reg_addr)
            5'd12: begin
              ie_q  <= bus.wdata[0];
              exl_q <= bus.wdata[1];
              im_q  <= bus.wdata[15:10];
            end
            5'd14:   epc_q <= bus.wdata;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.reg_addr)
      5'd12: bus.rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13: bus.rdata = {16'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      5'd14: bus.rdata = epc_q;
      5'd15: bus.rdata = PRID;
`ifdef CP0_TIMER_EN
      5'd9:  bus.rdata = count_q;
      5'd11: bus.rdata = compare_q;
`endif
      default: bus.rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0; timer section builds with CP0_TIMER_EN.
module tb_cp0;
  localparam logic [31:0] PRID = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cp0_if bus();

  cp0 #(.PRID(PRID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.syscall  = 1'b0;
    bus.brk      = 1'b0;
    bus.ri       = 1'b0;
    bus.ov       = 1'b0;
    bus.int_req  = 6'd0;
    bus.eret     = 1'b0;
    bus.cp0_rd   = 1'b0;
    bus.cp0_wr   = 1'b0;
    bus.reg_addr = 5'd0;
    bus.wdata    = 32'd0;
  endtask

  // One active edge, then return at the following falling edge to drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.cp0_rd   = 1'b1;
    bus.reg_addr = addr;
    #1;
    check(tag, bus.rdata, exp);
    bus.cp0_rd   = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.cp0_wr   = 1'b1;
    bus.reg_addr = addr;
    bus.wdata    = data;
    tick();
    bus.cp0_wr   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.inst_pc = 32'd0;
    idle();
    @(negedge clk);

    // Reset: exception forced low even with a syscall decode present.
    bus.syscall = 1'b1;
    #1 check("rst_exc", {31'd0, bus.exception}, 32'd0);
    check("rst_epc", bus.epc, 32'd0);
    bus.syscall = 1'b0;
    read_chk("rst_status", 5'd12, 32'd0);
    read_chk("rst_prid", 5'd15, PRID);
    tick();
    rst_n = 1'b1;
    tick();
    read_chk("rel_status", 5'd12, 32'd0);
    read_chk("rel_cause", 5'd13, 32'd0);
    read_chk("rel_epc", 5'd14, 32'd0);

    // Syscall then eret.
    bus.syscall = 1'b1;
    bus.inst_pc = 32'h0040_0010;
    #1 check("sys_exc", {31'd0, bus.exception}, 32'd1);
    tick();
    bus.syscall = 1'b0;
    read_chk("sys_epc", 5'd14, 32'h0040_0010);
    read_chk("sys_cause", 5'd13, 32'h0000_0020);
    read_chk("sys_status", 5'd12, 32'h0000_0002);
    bus.eret = 1'b1;
    #1 check("eret_epc", bus.epc, 32'h0040_0010);
    check("eret_noexc", {31'd0, bus.exception}, 32'd0);
    tick();
    bus.eret = 1'b0;
    read_chk("eret_status", 5'd12, 32'd0);

    // ri beats ov, and the same-cycle mtc0 to EPC is dropped.
    bus.ri = 1'b1;
    bus.ov = 1'b1;
    bus.inst_pc = 32'h0040_0020;
    bus.cp0_wr = 1'b1;
    bus.reg_addr = 5'd14;
    bus.wdata = 32'hDEAD_BEEF;
    #1 check("pri_exc", {31'd0, bus.exception}, 32'd1);
    tick();
    idle();
    read_chk("pri_epc", 5'd14, 32'h0040_0020);
    read_chk("pri_cause", 5'd13, 32'h0000_0028);

    // With EXL set, brk (over ov) is still taken and overwrites EPC.
    bus.brk = 1'b1;
    bus.ov  = 1'b1;
    bus.inst_pc = 32'h0040_0030;
    tick();
    idle();
    read_chk("brk_epc", 5'd14, 32'h0040_0030);
    read_chk("brk_cause", 5'd13, 32'h0000_0024);
    read_chk("brk_status", 5'd12, 32'h0000_0002);
    bus.ov = 1'b1;
    tick();
    bus.ov = 1'b0;
    read_chk("ov_cause", 5'd13, 32'h0000_0030);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;

    // Interrupt masking and IP registration delay.
    mtc0(5'd12, 32'h0000_0401);
    read_chk("int_status", 5'd12, 32'h0000_0401);
    bus.int_req = 6'b000001;
    bus.inst_pc = 32'h0040_0040;
    #1 check("int_delay", {31'd0, bus.exception}, 32'd0);
    tick();
    #1 check("int_fire", {31'd0, bus.exception}, 32'd1);
    read_chk("int_ip", 5'd13, 32'h0000_0430);
    bus.eret = 1'b1;
    #1 check("int_eret_block", {31'd0, bus.exception}, 32'd0);
    bus.eret = 1'b0;
    tick();
    read_chk("int_cause", 5'd13, 32'h0000_0400);
    read_chk("int_epc", 5'd14, 32'h0040_0040);
    #1 check("int_exl_block", {31'd0, bus.exception}, 32'd0);
    bus.int_req = 6'd0;
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    read_chk("int_ret_status", 5'd12, 32'h0000_0401);

    // Read decode and writable-field masks.
    mtc0(5'd12, 32'hFFFF_FFFF);
    read_chk("st_mask", 5'd12, 32'h0000_FC03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    read_chk("cause_ro", 5'd13, 32'h0000_0000);
    mtc0(5'd14, 32'h1234_5678);
    read_chk("epc_rw", 5'd14, 32'h1234_5678);
    check("epc_out", bus.epc, 32'h1234_5678);
    read_chk("rd_0", 5'd0, 32'd0);
    read_chk("rd_31", 5'd31, 32'd0);
`ifndef CP0_TIMER_EN
    read_chk("rd_9", 5'd9, 32'd0);
    read_chk("rd_11", 5'd11, 32'd0);
`endif

    // Asynchronous reset mid-cycle clears state at once.
    rst_n = 1'b0;
    #1;
    read_chk("mid_rst_epc", 5'd14, 32'd0);
    read_chk("mid_rst_status", 5'd12, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.exception) break;
      tick();
    end
    check("tmr_exc", {31'd0, bus.exception}, 32'd1);
    read_chk("tmr_ip", 5'd13, 32'h0000_8000);
    tick();
    mtc0(5'd11, 32'd0);
    tick();
    read_chk("tmr_clr", 5'd13, 32'h0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
